// File: rtl/fifo_rr_write_arbiter_if.sv
// Producer/FIFO write-side bundle for the round-robin write arbiter.
// master: the producers + FIFO side; slave: the arbiter.
interface fifo_rr_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_w_en;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic [ID_W-1:0]               grant_id;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_w_en, fifo_wdata, grant_id
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_w_en, fifo_wdata, grant_id
  );
endinterface

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A producer that wins keeps the port for up to MAX_BURST consecutive writes
// while it stays valid; a full FIFO stalls without consuming burst credit.
module fifo_rr_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_rr_write_arbiter_if.slave bus
);
  localparam int              CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ID_W-1:0]  LAST_RST  = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]  last_ptr_q, last_ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic             owner_valid_q, owner_valid_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_words;
  logic                               hold, has_win, xfer;
  logic [ID_W-1:0]                    win;

  assign req_words = bus.req_data;

  // Winner: current owner while its burst lasts, else first valid after last_ptr.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_id;
    idx     = 0;
    idx_id  = '0;
    has_win = 1'b0;
    win     = '0;
    hold    = owner_valid_q && bus.req_valid[owner_q] && (burst_cnt_q < BURST_MAX);
    if (hold) begin
      has_win = 1'b1;
      win     = owner_q;
    end else begin
      // Scan farthest-first so the nearest valid producer overwrites last.
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx    = (int'(last_ptr_q) + k) % NUM_REQ;
        idx_id = ID_W'(idx);
        if (bus.req_valid[idx_id]) begin
          has_win = 1'b1;
          win     = idx_id;
        end
      end
    end
  end

  // Handshake and FIFO write outputs; everything forced quiet during reset.
  always_comb begin
    xfer           = has_win & ~bus.fifo_full & rst_n;
    bus.fifo_w_en  = xfer;
    bus.req_ready  = '0;
    if (xfer) bus.req_ready[win] = 1'b1;
    bus.grant_id   = xfer ? win : '0;
    bus.fifo_wdata = (has_win && rst_n) ? req_words[win] : '0;
  end

  // Next-state: reset, advance on a write, clear ownership when idle, hold on stall.
  always_comb begin
    last_ptr_d    = last_ptr_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    burst_cnt_d   = burst_cnt_q;
    if (!rst_n) begin
      last_ptr_d    = LAST_RST;
      owner_d       = '0;
      owner_valid_d = 1'b0;
      burst_cnt_d   = '0;
    end else if (xfer) begin
      last_ptr_d    = win;
      owner_d       = win;
      owner_valid_d = 1'b1;
      // Only a hold-case win continues the burst; a rotation win restarts it,
      // including the sole-valid owner regaining the port after exhaustion.
      burst_cnt_d   = hold ? burst_cnt_q + CNT_ONE : CNT_ONE;
    end else if (!has_win) begin
      owner_valid_d = 1'b0;
      burst_cnt_d   = '0;
    end
  end

  // State registers (reset is folded into the _d logic).
  always_ff @(posedge clk) begin
    last_ptr_q    <= last_ptr_d;
    owner_q       <= owner_d;
    owner_valid_q <= owner_valid_d;
    burst_cnt_q   <= burst_cnt_d;
  end
endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Vector-table bench for fifo_rr_write_arbiter: a 4-producer MAX_BURST=4
// instance and a 3-producer MAX_BURST=1 instance, expectations via a queue.
module tb_fifo_rr_write_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  fifo_rr_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) b4 ();
  fifo_rr_write_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8)) b3 ();

  fifo_rr_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave));
  fifo_rr_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3.slave));

  // gid is the expected winner whenever rst=1 and any valid, even if stalled.
  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       full;
    logic       wen;
    logic [1:0] gid;
    string      name;
  } vec_t;

  typedef struct {
    logic       wen;
    logic [1:0] gid;
    logic [3:0] rdy;
    logic [7:0] wdata;
    string      name;
  } exp_t;

  vec_t t4[$];
  vec_t t3[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   step   = 0;

  function automatic vec_t mk(logic r, logic [3:0] v, logic f, logic w, logic [1:0] g, string n);
    vec_t x;
    x.rst = r; x.valid = v; x.full = f; x.wen = w; x.gid = g; x.name = n;
    return x;
  endfunction

  function automatic logic [7:0] word(int s, int i);
    return 8'(((s & 15) << 4) | i);
  endfunction

  task automatic apply(input bit sel3, input vec_t v);
    exp_t       e, got;
    logic [1:0] g;
    @(posedge clk);
    #1;
    step++;
    rst_n = v.rst;
    if (sel3) begin
      b3.req_valid = v.valid[2:0];
      b3.fifo_full = v.full;
      for (int i = 0; i < 3; i++) b3.req_data[i*8 +: 8] = word(step, i);
    end else begin
      b4.req_valid = v.valid;
      b4.fifo_full = v.full;
      for (int i = 0; i < 4; i++) b4.req_data[i*8 +: 8] = word(step, i);
    end
    g       = v.gid;
    e.wen   = v.wen;
    e.gid   = v.wen ? g : 2'd0;
    e.rdy   = v.wen ? (4'b0001 << g) : 4'b0000;
    e.wdata = (v.rst && (v.valid != 4'b0000)) ? word(step, int'(g)) : 8'h00;
    e.name  = v.name;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    if (sel3) begin
      got.wen = b3.fifo_w_en; got.gid = b3.grant_id;
      got.rdy = {1'b0, b3.req_ready}; got.wdata = b3.fifo_wdata;
    end else begin
      got.wen = b4.fifo_w_en; got.gid = b4.grant_id;
      got.rdy = b4.req_ready; got.wdata = b4.fifo_wdata;
    end
    n_vec++;
    if (got.wen !== e.wen || got.gid !== e.gid || got.rdy !== e.rdy || got.wdata !== e.wdata) begin
      n_miss++;
      $display("FAIL %s step %0d: got wen=%b gid=%0d rdy=%b wdata=%h, want wen=%b gid=%0d rdy=%b wdata=%h",
               e.name, step, got.wen, got.gid, got.rdy, got.wdata, e.wen, e.gid, e.rdy, e.wdata);
    end
  endtask

  initial begin
    // 4-producer table
    for (int i = 0; i < 2; i++) t4.push_back(mk(0, 4'hF, 0, 0, 0, "reset_quiet"));
    for (int i = 0; i < 17; i++) t4.push_back(mk(1, 4'hF, 0, 1, 2'((i / 4) % 4), "all_valid_rr"));
    for (int i = 0; i < 10; i++) t4.push_back(mk(1, 4'b0100, 0, 1, 2, "single_p2"));
    t4.push_back(mk(1, 4'b0000, 0, 0, 0, "idle"));
    for (int i = 0; i < 2; i++) t4.push_back(mk(1, 4'b0011, 0, 1, 0, "p0_burst_pre"));
    for (int i = 0; i < 3; i++) t4.push_back(mk(1, 4'b0011, 1, 0, 0, "full_stall"));
    for (int i = 0; i < 2; i++) t4.push_back(mk(1, 4'b0011, 0, 1, 0, "p0_burst_post"));
    for (int i = 0; i < 2; i++) t4.push_back(mk(1, 4'b0011, 0, 1, 1, "p1_after_p0"));
    t4.push_back(mk(1, 4'b1000, 0, 1, 3, "owner_drop"));
    for (int i = 0; i < 3; i++) t4.push_back(mk(1, 4'b1010, 0, 1, 3, "p3_keeps"));
    t4.push_back(mk(1, 4'b1010, 0, 1, 1, "p1_rotation"));
    t4.push_back(mk(1, 4'hF, 0, 1, 1, "pre_reset_hold"));
    for (int i = 0; i < 2; i++) t4.push_back(mk(0, 4'hF, 0, 0, 0, "reset_mid_burst"));
    for (int i = 0; i < 4; i++) t4.push_back(mk(1, 4'hF, 0, 1, 0, "post_reset_p0"));
    t4.push_back(mk(1, 4'hF, 0, 1, 1, "post_reset_p1"));
    // 3-producer table, MAX_BURST=1
    for (int i = 0; i < 6; i++) t3.push_back(mk(1, 4'b0101, 0, 1, 2'((i % 2) * 2), "n3_alternate"));
    for (int i = 0; i < 3; i++) t3.push_back(mk(1, 4'b0100, 0, 1, 2, "n3_sole_p2"));
    t3.push_back(mk(1, 4'b0101, 0, 1, 0, "n3_wrap_to_0"));
    t3.push_back(mk(1, 4'b0101, 1, 0, 2, "n3_full"));
    t3.push_back(mk(1, 4'b0101, 0, 1, 2, "n3_after_full"));

    rst_n = 1'b0;
    b4.req_valid = '0; b4.req_data = '0; b4.fifo_full = 1'b0;
    b3.req_valid = '0; b3.req_data = '0; b3.fifo_full = 1'b0;

    foreach (t4[i]) apply(1'b0, t4[i]);
    @(posedge clk);
    #1;
    b4.req_valid = '0;
    foreach (t3[i]) apply(1'b1, t3[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
